// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window MAC: FSM state encoding,
// index-width helper and the product sign/zero-extension function.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } conv_state_t;

  // Widest accumulator the extension helper can serve.
  localparam int CONV_MAX_W = 64;

  // Index width for the default 5x5 window.
  localparam int CONV_IDX_W_DEF = $clog2(5 * 5);

  // Bits needed to address N window elements (at least one bit).
  function automatic int conv_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Extend a prod_w-bit product held in the low bits of prod to the full
  // CONV_MAX_W width: sign-extend when sgn is set, zero-extend otherwise.
  function automatic logic [CONV_MAX_W-1:0] conv_extend(
    input logic [CONV_MAX_W-1:0] prod,
    input int                    prod_w,
    input logic                  sgn
  );
    logic [CONV_MAX_W-1:0] r;
    r = prod;
    for (int i = 0; i < CONV_MAX_W; i++) begin
      if (i >= prod_w) r[i] = sgn & prod[prod_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One multiply lane: DATA_W x DATA_W product, extended to ACC_W according
// to the captured signed/unsigned mode.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  output logic [ACC_W-1:0]  prod_ext
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod_s;

  // Operands are widened by mode so a single multiplier serves both modes;
  // the low 2*DATA_W bits of the product are exact in either case.
  assign a_x    = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
  assign b_x    = {{DATA_W{signed_mode & b[DATA_W-1]}}, b};
  assign prod_s = a_x * b_x;

  assign prod_ext = ACC_W'(conv_extend(CONV_MAX_W'($unsigned(prod_s)), 2 * DATA_W, signed_mode));

endmodule

// File: rtl/conv_window_mac.sv
// Sequential K x K convolution window multiply-accumulate engine.
// Snapshots a window on start, accumulates LANES products per cycle onto a
// bias, and presents the result on a valid/ready output.
// Optional feature: define CONV_WINDOW_RELU_EN to present ReLU(result) in
// signed mode (the accumulator itself is left untouched).
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int K      = 5,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LANES  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             signed_mode,
  input  logic [K-1:0][K-1:0][DATA_W-1:0]  inputs,
  input  logic [K-1:0][K-1:0][DATA_W-1:0]  weights,
  input  logic [ACC_W-1:0]                 bias,
  output logic                             busy,
  output logic [ACC_W-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int N     = K * K;
  localparam int IDX_W = conv_idx_w(N);

  if (LANES < 1 || (N % LANES) != 0) begin : g_lanes_chk
    $error("conv_window_mac: LANES must divide K*K");
  end
  if (ACC_W < 2 * DATA_W || ACC_W > CONV_MAX_W) begin : g_acc_chk
    $error("conv_window_mac: ACC_W must be in [2*DATA_W, 64]");
  end

  conv_state_t state_q, state_d;
  logic        capture;
  logic        step;
  logic        last_group;

  // Flat row-major view: element e sits at row e/K, column e%K, which is
  // exactly the bit layout of the packed [K][K] window ports.
  logic [N-1:0][DATA_W-1:0] act_q;
  logic [N-1:0][DATA_W-1:0] wgt_q;
  logic                     mode_q;
  logic [ACC_W-1:0]         acc_q;
  logic [IDX_W-1:0]         idx_q;

  logic [DATA_W-1:0] lane_a    [LANES];
  logic [DATA_W-1:0] lane_b    [LANES];
  logic [ACC_W-1:0]  lane_prod [LANES];
  logic [ACC_W-1:0]  group_sum;

  assign last_group = (idx_q == IDX_W'(N - LANES));

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    assign lane_a[gl] = act_q[idx_q + IDX_W'(gl)];
    assign lane_b[gl] = wgt_q[idx_q + IDX_W'(gl)];

    conv_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .a           (lane_a[gl]),
      .b           (lane_b[gl]),
      .signed_mode (mode_q),
      .prod_ext    (lane_prod[gl])
    );
  end

  // Sum of this cycle's lane products, wrapping in ACC_W.
  always_comb begin
    group_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      group_sum = group_sum + lane_prod[l];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept a window in IDLE or on a HOLD handshake,
  // step through groups in RUN, park in HOLD until the result is taken.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_group) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            capture = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window snapshot and accumulation; the index wraps to 0 on the last
  // group so it never addresses past the window while in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= '0;
      wgt_q  <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (capture) begin
      act_q  <= inputs;
      wgt_q  <= weights;
      mode_q <= signed_mode;
      acc_q  <= bias;
      idx_q  <= '0;
    end else if (step) begin
      acc_q  <= acc_q + group_sum;
      idx_q  <= last_group ? '0 : idx_q + IDX_W'(LANES);
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);

`ifdef CONV_WINDOW_RELU_EN
  function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v, input logic sgn);
    return (sgn && v[ACC_W-1]) ? '0 : v;
  endfunction

  assign out_data = relu(acc_q, mode_q);
`else
  assign out_data = acc_q;
`endif

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Parametrised sequential multiply-accumulate engine for one K×K convolution window, successor to the fixed 5×5 unsigned convolution block. It snapshots a window of activations and weights on `start`. It accumulates LANES products per cycle onto a bias, in signed or unsigned mode, and presents the result on a valid/ready output so downstream buffers can apply backpressure. It sits between the line-buffer/window generator and the output feature-map writer.

## Interface
- `K`, default 5: window side; window holds N = K*K elements.
- `DATA_W`, default 8: activation and weight width.
- `ACC_W`, default 32: accumulator, bias and result width; must be ≥ 2*DATA_W.
- `LANES`, default 1: products per cycle; must divide N, otherwise elaboration error.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new window; sampled only when accepted (see Operation).
- `signed_mode` in 1: 1 = operands are two's complement; captured with `start`.
- `inputs` in [K-1:0][K-1:0][DATA_W]: activation window, row-major.
- `weights` in [K-1:0][K-1:0][DATA_W]: kernel window, row-major.
- `bias` in ACC_W: initial accumulator value; captured with `start`.
- `busy` out 1: high whenever state ≠ IDLE.
- `out_data` out ACC_W: result; stable while `out_valid` is high.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.

## Operation
- States: IDLE, RUN, HOLD.
- **IDLE**
  - `start` = 1 → capture `inputs`, `weights`, `signed_mode` into internal registers.
  - Load `bias` into the accumulator, clear index to 0, go to RUN.
- **RUN**
  - Each cycle the accumulator adds the products of elements idx..idx+LANES-1, in row-major flat order (element e = row e/K, column e%K).
  - Index advances by LANES.
  - On the cycle processing the last group (idx+LANES = N) → go to HOLD and assert `out_valid`.
  - `start` is ignored.
- **HOLD**
  - `out_valid` = 1 and `out_data` is frozen.
  - `out_ready` = 1 → handshake completes and `out_valid` drops next edge.
    - If `start` = 1 in that same cycle → capture a new window and go directly to RUN (back-to-back).
    - Otherwise → IDLE.
  - `start` without `out_ready` is ignored.
- **Arithmetic**
  - Each product is 2*DATA_W bits.
  - Products are sign-extended (signed mode) or zero-extended (unsigned) to ACC_W.
  - The LANES products are summed in ACC_W and added to the accumulator.
  - All additions wrap modulo 2^ACC_W; no saturation.
- Inputs changing after capture have no effect on the window in flight.

## Timing
- Reset values: `busy` = 0, `out_valid` = 0, `out_data` = 0.
  - Internal accumulator, index, captured mode and operand registers all 0.
  - State IDLE.
- Latency: `out_valid` rises N/LANES rising edges after the edge that accepts `start`.
  - K=5, LANES=1: 25 cycles.
  - K=5, LANES=5: 5 cycles.
- Throughput with `out_ready` tied high: one window per N/LANES+1 cycles. The HOLD cycle is always at least one cycle.
- `rst_n` asserted mid-RUN or mid-HOLD:
  - Immediate abort; outputs return to their reset values asynchronously.
  - The partial result is discarded.
  - No `out_valid` pulse after reset release until a new `start`.
- `out_valid` never deasserts without a handshake or reset.

## Configuration
- Macro `CONV_WINDOW_RELU_EN`.
- Defined: `out_data` is the ReLU of the accumulator. In signed mode, a negative result (MSB = 1) is presented as 0. In unsigned mode it passes through.
- Undefined: `out_data` is the raw accumulator.
- The accumulator itself is never modified by ReLU.

## Structure
- Shared package `conv_pkg`:
  - state enum `conv_state_t` (IDLE, RUN, HOLD).
  - index width constant derived from N via $clog2.
  - sign/zero-extension function for products.
- Sub-module `conv_mac_lane`: one DATA_W×DATA_W multiplier with signed_mode-controlled extension to ACC_W, instantiated LANES times in a generate loop.

## Test plan
- K=5, LANES=1, unsigned, all inputs = 1, all weights = 1, bias = 0 → `out_valid` 25 cycles after `start`, `out_data` = 25, `busy` high throughout.
- Signed, inputs = 3, weights = 0xFF (−1), bias = 10 → `out_data` = 0xFFFFFFBF (−65).
  - With `CONV_WINDOW_RELU_EN` defined: `out_data` = 0.
- LANES=5, same all-ones stimulus, bias = 7 → `out_data` = 32 after 5 cycles. Operands changed one cycle after `start` leave the result unchanged.
- `out_ready` held low 10 cycles in HOLD, with `start` pulsed → `out_valid` and `out_data` stable, `start` ignored.
  - Then `out_ready` = 1 with `start` = 1 → next window runs with no IDLE cycle.
- ACC_W=16, unsigned, all inputs and weights = 255, bias = 0 → `out_data` = 52761 (1625625 mod 65536, wrap-around).
- `rst_n` pulsed low at cycle 12 of RUN → `busy`, `out_valid` and `out_data` are 0 immediately. A subsequent `start` yields a correct, independent result.
